aidc_aw_sched: RTL and testbench



---
 rtl/aidc_aw_sched.sv | 185 ++++++++++++++++++
 tb/tb_aidc_aw_sched.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aidc_aw_sched.sv
// aidc_aw_sched: holds icnt write addresses until the compressor reports the
// burst result, then reissues them to the memory controller with awlen
// rewritten to the compressed beat count. Also gates icnt W on AW credit and
// bounds MC writes in flight until their B responses return.
module aidc_aw_sched #(
  parameter int ADDR_W  = 32,
  parameter int ID_W    = 4,
  parameter int DEPTH   = 4,
  parameter int MAX_OUT = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              icnt_awvalid,
  output logic              icnt_awready,
  input  logic [ADDR_W-1:0] icnt_awaddr,
  input  logic [ID_W-1:0]   icnt_awid,
  input  logic [7:0]        icnt_awlen,
  input  logic              w_last_hs,
  output logic              w_gate,
  input  logic              res_valid,
  input  logic              res_comp,
  input  logic [7:0]        res_len,
  output logic              mc_awvalid,
  input  logic              mc_awready,
  output logic [ADDR_W-1:0] mc_awaddr,
  output logic [ID_W-1:0]   mc_awid,
  output logic [7:0]        mc_awlen,
  input  logic              mc_b_hs,
  output logic [7:0]        outstanding,
  output logic              err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, WAIT_RES, ISSUE} state_t;

  state_t            state;
  logic [ADDR_W-1:0] q_addr [DEPTH];
  logic [ID_W-1:0]   q_id   [DEPTH];
  logic [7:0]        q_len  [DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     q_cnt, credit;
  logic              hold_v, hold_comp;
  logic [7:0]        hold_len;
  logic [7:0]        out_cnt;
  logic              err_r;
  logic              awvalid_r;
  logic [ADDR_W-1:0] awaddr_r;
  logic [ID_W-1:0]   awid_r;
  logic [7:0]        awlen_r;

  logic full, push, pop, room, res_any, sel_comp, load;
  logic [7:0] sel_len;

  always_comb begin
    full     = (q_cnt == CW'(DEPTH));
    push     = icnt_awvalid & icnt_awready;
    pop      = awvalid_r & mc_awready;
    room     = (out_cnt < 8'(MAX_OUT));
    res_any  = hold_v | res_valid;
    sel_comp = hold_v ? hold_comp : res_comp;
    sel_len  = hold_v ? hold_len  : res_len;
    // Head present, a result available (held or arriving now) and MC room.
    load     = (state != ISSUE) && (q_cnt != '0) && res_any && room;
  end

  assign icnt_awready = !rst && !full;
  assign w_gate       = !rst && (credit != '0);
  assign mc_awvalid   = !rst && awvalid_r;
  assign mc_awaddr    = rst ? '0 : awaddr_r;
  assign mc_awid      = rst ? '0 : awid_r;
  assign mc_awlen     = rst ? '0 : awlen_r;
  assign outstanding  = rst ? '0 : out_cnt;
  assign err          = !rst && err_r;

  // AW queue storage (data only, no reset needed)
  always_ff @(posedge clk) begin
    if (push) begin
      q_addr[wr_ptr] <= icnt_awaddr;
      q_id[wr_ptr]   <= icnt_awid;
      q_len[wr_ptr]  <= icnt_awlen;
    end
  end

  // AW queue pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      q_cnt  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      q_cnt <= q_cnt + CW'(push) - CW'(pop);
    end
  end

  // W credit: one per queued AW, returned on each completed W burst
  always_ff @(posedge clk) begin
    if (rst) begin
      credit <= '0;
    end else if (push && !w_last_hs && credit != CW'(DEPTH)) begin
      credit <= credit + CW'(1);
    end else if (!push && w_last_hs && credit != '0) begin
      credit <= credit - CW'(1);
    end
  end

  // Result holding register. The result is consumed when it is loaded into
  // the MC payload, so the register is free again while ISSUE waits on ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_v    <= 1'b0;
      hold_comp <= 1'b0;
      hold_len  <= '0;
    end else begin
      if (load) hold_v <= hold_v & res_valid;
      else if (res_valid && !hold_v) hold_v <= 1'b1;
      if (res_valid && (load || !hold_v)) begin
        hold_comp <= res_comp;
        hold_len  <= res_len;
      end
    end
  end

  // MC writes in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      out_cnt <= '0;
    end else if (pop && !mc_b_hs) begin
      out_cnt <= out_cnt + 8'd1;
    end else if (!pop && mc_b_hs && out_cnt != '0) begin
      out_cnt <= out_cnt - 8'd1;
    end
  end

  // Sticky protocol error: W/B underflow or result overrun
  always_ff @(posedge clk) begin
    if (rst) begin
      err_r <= 1'b0;
    end else if ((w_last_hs && credit == '0) || (mc_b_hs && out_cnt == '0) ||
                 (res_valid && hold_v && !load)) begin
      err_r <= 1'b1;
    end
  end

  // Issue FSM with registered MC AW payload
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      awvalid_r <= 1'b0;
      awaddr_r  <= '0;
      awid_r    <= '0;
      awlen_r   <= '0;
    end else begin
      case (state)
        IDLE, WAIT_RES: begin
          if (load) begin
            state     <= ISSUE;
            awvalid_r <= 1'b1;
            awaddr_r  <= q_addr[rd_ptr];
            awid_r    <= q_id[rd_ptr];
            awlen_r   <= sel_comp ? sel_len : q_len[rd_ptr];
          end else if (q_cnt != '0) begin
            state <= WAIT_RES;
          end else begin
            state <= IDLE;
          end
        end
        ISSUE: begin
          if (mc_awready) begin
            awvalid_r <= 1'b0;
            state     <= (q_cnt > CW'(1) || push) ? WAIT_RES : IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          awvalid_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aidc_aw_sched.sv
// Testbench for aidc_aw_sched: directed scenarios plus a randomized run
// checked against a transaction-level queue model.
module tb_aidc_aw_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        icnt_awvalid, icnt_awready;
  logic [31:0] icnt_awaddr;
  logic [3:0]  icnt_awid;
  logic [7:0]  icnt_awlen;
  logic        w_last_hs, w_gate;
  logic        res_valid, res_comp;
  logic [7:0]  res_len;
  logic        mc_awvalid, mc_awready;
  logic [31:0] mc_awaddr;
  logic [3:0]  mc_awid;
  logic [7:0]  mc_awlen;
  logic        mc_b_hs;
  logic [7:0]  outstanding;
  logic        err;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  id;
    logic [7:0]  len;
  } aw_t;

  aidc_aw_sched #(.ADDR_W(32), .ID_W(4), .DEPTH(4), .MAX_OUT(2)) dut (
    .clk(clk), .rst(rst),
    .icnt_awvalid(icnt_awvalid), .icnt_awready(icnt_awready),
    .icnt_awaddr(icnt_awaddr), .icnt_awid(icnt_awid), .icnt_awlen(icnt_awlen),
    .w_last_hs(w_last_hs), .w_gate(w_gate),
    .res_valid(res_valid), .res_comp(res_comp), .res_len(res_len),
    .mc_awvalid(mc_awvalid), .mc_awready(mc_awready),
    .mc_awaddr(mc_awaddr), .mc_awid(mc_awid), .mc_awlen(mc_awlen),
    .mc_b_hs(mc_b_hs), .outstanding(outstanding), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    icnt_awvalid = 0; icnt_awaddr = '0; icnt_awid = '0; icnt_awlen = '0;
    w_last_hs = 0; res_valid = 0; res_comp = 0; res_len = '0;
    mc_awready = 0; mc_b_hs = 0;
  endtask

  task automatic do_reset();
    rst = 1;
    idle_inputs();
    tick();
    tick();
    @(negedge clk);
    chk("rst_awready", icnt_awready, 0);
    chk("rst_mcvalid", mc_awvalid, 0);
    chk("rst_wgate", w_gate, 0);
    chk("rst_out", outstanding, 0);
    chk("rst_err", err, 0);
    chk("rst_payload", {mc_awaddr, mc_awid, mc_awlen}, 0);
    tick();
    rst = 0;
    @(negedge clk);
    chk("post_rst_awready", icnt_awready, 1);
    tick();
  endtask

  task automatic push_aw(input logic [31:0] a, input logic [3:0] i, input logic [7:0] l);
    icnt_awvalid = 1; icnt_awaddr = a; icnt_awid = i; icnt_awlen = l;
    @(negedge clk);
    chk("push_awready", icnt_awready, 1);
    tick();
    icnt_awvalid = 0;
  endtask

  task automatic wait_hs(input string tag, input logic [3:0] eid, input logic [7:0] elen);
    bit found;
    found = 0;
    for (int n = 0; n < 20 && !found; n++) begin
      @(negedge clk);
      if (mc_awvalid && mc_awready) begin
        found = 1;
        chk({tag, "_id"}, mc_awid, eid);
        chk({tag, "_len"}, mc_awlen, elen);
      end
      tick();
    end
    chk({tag, "_seen"}, found, 1);
  endtask

  // One AW through the whole path, then its W and B complete
  task automatic single(input logic [31:0] a, input logic [3:0] i, input logic [7:0] l,
                        input logic c, input logic [7:0] rl, input logic [7:0] el);
    icnt_awvalid = 1; icnt_awaddr = a; icnt_awid = i; icnt_awlen = l;
    @(negedge clk);
    chk("s_awready", icnt_awready, 1);
    tick();
    icnt_awvalid = 0; res_valid = 1; res_comp = c; res_len = rl;
    @(negedge clk);
    chk("s_wgate", w_gate, 1);
    chk("s_early_valid", mc_awvalid, 0);
    tick();
    res_valid = 0; mc_awready = 1;
    @(negedge clk);
    chk("s_valid", mc_awvalid, 1);
    chk("s_len", mc_awlen, el);
    chk("s_addr", mc_awaddr, a);
    chk("s_id", mc_awid, i);
    tick();
    mc_awready = 0; w_last_hs = 1;
    @(negedge clk);
    chk("s_out1", outstanding, 1);
    chk("s_valid_drop", mc_awvalid, 0);
    tick();
    w_last_hs = 0; mc_b_hs = 1;
    @(negedge clk);
    chk("s_wgate_off", w_gate, 0);
    tick();
    mc_b_hs = 0;
    @(negedge clk);
    chk("s_out0", outstanding, 0);
    chk("s_err", err, 0);
    tick();
  endtask

  aw_t         awq[$];
  aw_t         expq[$];
  aw_t         a, e;
  int          credit_m, out_m;
  bit          stall_p, drain;
  logic [43:0] stall_pl;

  initial begin
    do_reset();

    // Basic path: compressed and uncompressed results
    single(32'h1000, 4'd3, 8'd7, 1'b1, 8'd2, 8'd2);
    single(32'h2000, 4'd5, 8'd15, 1'b0, 8'd2, 8'd15);

    // Fill the queue, return W credit, then drain in order
    for (int k = 0; k < 4; k++) push_aw(32'h3000 + 32'(k * 64), 4'(k), 8'(k + 4));
    icnt_awvalid = 1; icnt_awid = 4'hf;
    @(negedge clk);
    chk("f_full", icnt_awready, 0);
    chk("f_wgate", w_gate, 1);
    tick();
    icnt_awvalid = 0; w_last_hs = 1;
    tick(); tick(); tick();
    w_last_hs = 0;
    @(negedge clk);
    chk("f_wgate_3", w_gate, 1);
    tick();
    w_last_hs = 1;
    tick();
    w_last_hs = 0;
    @(negedge clk);
    chk("f_wgate_0", w_gate, 0);
    mc_awready = 1;
    for (int k = 0; k < 4; k++) begin
      res_valid = 1; res_comp = 1'(k); res_len = 8'(k + 100);
      tick();
      res_valid = 0;
      wait_hs("f_issue", 4'(k), k[0] ? 8'(k + 100) : 8'(k + 4));
      if (k == 0) begin
        @(negedge clk);
        chk("f_room", icnt_awready, 1);
      end
      mc_b_hs = 1;
      tick();
      mc_b_hs = 0;
    end
    mc_awready = 0;

    // MC writes in flight limit
    for (int k = 0; k < 3; k++) push_aw(32'h5000 + 32'(k * 16), 4'(10 + k), 8'd1);
    mc_awready = 1;
    for (int k = 0; k < 2; k++) begin
      res_valid = 1; res_comp = 1; res_len = 8'(k);
      tick();
      res_valid = 0;
      wait_hs("mo_issue", 4'(10 + k), 8'(k));
    end
    @(negedge clk);
    chk("mo_out2", outstanding, 2);
    res_valid = 1; res_comp = 0; res_len = 8'd0;
    tick();
    res_valid = 0;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      chk("mo_withheld", mc_awvalid, 0);
      tick();
    end
    mc_b_hs = 1;
    tick();
    mc_b_hs = 0;
    tick();
    @(negedge clk);
    chk("mo_next_valid", mc_awvalid, 1);
    chk("mo_next_id", mc_awid, 12);
    chk("mo_next_len", mc_awlen, 1);
    tick();
    mc_awready = 0; w_last_hs = 1; mc_b_hs = 1;
    tick(); tick();
    mc_b_hs = 0;
    tick();
    w_last_hs = 0;
    @(negedge clk);
    chk("mo_out0", outstanding, 0);
    chk("mo_wgate0", w_gate, 0);
    chk("mo_err", err, 0);
    tick();

    // Randomized traffic against the transaction-level model
    do_reset();
    credit_m = 0; out_m = 0; stall_p = 0; stall_pl = '0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      drain = (cyc >= 1300);
      icnt_awvalid = !drain && credit_m < 4 && ($urandom % 3 == 0);
      icnt_awaddr  = $urandom;
      icnt_awid    = 4'($urandom);
      icnt_awlen   = 8'($urandom);
      res_valid    = expq.size() == 0 && awq.size() > 0 && ($urandom % 2 == 0);
      res_comp     = 1'($urandom);
      res_len      = 8'($urandom);
      w_last_hs    = credit_m > 0 && ($urandom % 3 == 0);
      mc_awready   = drain ? 1'b1 : 1'($urandom);
      mc_b_hs      = out_m > 0 && ($urandom % 3 == 0);
      @(negedge clk);
      chk("r_out", outstanding, 64'(out_m));
      chk("r_wgate", w_gate, credit_m != 0);
      chk("r_awready", icnt_awready, (awq.size() + expq.size()) < 4);
      chk("r_err", err, 0);
      chk("r_valid_unexpected", mc_awvalid && expq.size() == 0, 0);
      if (stall_p) begin
        chk("r_stall_valid", mc_awvalid, 1);
        chk("r_stall_payload", {mc_awaddr, mc_awid, mc_awlen}, stall_pl);
      end
      stall_p  = mc_awvalid && !mc_awready;
      stall_pl = {mc_awaddr, mc_awid, mc_awlen};
      if (res_valid) begin
        a = awq.pop_front();
        if (res_comp) a.len = res_len;
        expq.push_back(a);
      end
      if (icnt_awvalid && icnt_awready) begin
        awq.push_back({icnt_awaddr, icnt_awid, icnt_awlen});
        credit_m++;
      end
      if (w_last_hs) credit_m--;
      if (mc_awvalid && mc_awready && expq.size() > 0) begin
        e = expq.pop_front();
        chk("r_payload", {mc_awaddr, mc_awid, mc_awlen}, e);
        out_m++;
      end
      if (mc_b_hs) out_m--;
      tick();
    end
    idle_inputs();
    chk("r_drained", awq.size() + expq.size(), 0);

    // MC stall: stable payload, second result held, third flags err
    do_reset();
    for (int k = 0; k < 3; k++) push_aw(32'h4000 + 32'(k * 16), 4'(8 + k), 8'(20 + k));
    res_valid = 1; res_comp = 1; res_len = 8'd5;
    tick();
    res_valid = 0;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      chk("st_valid", mc_awvalid, 1);
      chk("st_payload", {mc_awaddr, mc_awid, mc_awlen}, {32'h4000, 4'd8, 8'd5});
      chk("st_err", err, n == 4);
      tick();
      res_valid = (n == 0 || n == 2);
      res_comp = 0; res_len = 8'd0;
    end
    res_valid = 0; mc_awready = 1;
    @(negedge clk);
    chk("st_hs_valid", mc_awvalid, 1);
    tick();
    mc_awready = 0;
    @(negedge clk);
    chk("st_single_hs", mc_awvalid, 0);
    chk("st_out1", outstanding, 1);
    tick();
    @(negedge clk);
    chk("st_second_valid", mc_awvalid, 1);
    chk("st_second_id", mc_awid, 9);
    chk("st_second_len", mc_awlen, 21);

    // W underflow, then reset in the middle of ISSUE
    tick();
    do_reset();
    w_last_hs = 1;
    tick();
    w_last_hs = 0;
    @(negedge clk);
    chk("u_err", err, 1);
    tick();
    push_aw(32'h6000, 4'd1, 8'd3);
    res_valid = 1; res_comp = 1; res_len = 8'd1;
    tick();
    res_valid = 0;
    @(negedge clk);
    chk("m_issue", mc_awvalid, 1);
    tick();
    rst = 1;
    @(negedge clk);
    chk("m_rst_valid", mc_awvalid, 0);
    chk("m_rst_awready", icnt_awready, 0);
    chk("m_rst_err", err, 0);
    chk("m_rst_wgate", w_gate, 0);
    tick();
    do_reset();
    @(negedge clk);
    chk("m_post_err", err, 0);
    chk("m_post_valid", mc_awvalid, 0);
    chk("m_post_out", outstanding, 0);
    chk("m_post_wgate", w_gate, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
